// File: rtl/conv_1st_loader.sv
// conv_1st_loader: loads bias words and packed pixel scan words into the first conv layer, then pulses sta
module conv_1st_loader #(
  parameter int NUM_PIX   = 300,
  parameter int NUM_BIAS  = 34,
  parameter int SCAN_IDLE = 127,
  parameter int BIAS_IDLE = 63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        skip_bias,
  input  logic        bias_valid,
  input  logic [15:0] bias_data,
  output logic        bias_ready,
  input  logic        pix_valid,
  input  logic [7:0]  pix_data,
  output logic        pix_ready,
  output logic [39:0] scan_o,
  output logic [23:0] bias_o,
  output logic        sta,
  output logic        busy,
  output logic        done
);
  localparam int PW = $clog2(NUM_PIX);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BIAS  = 2'd1;
  localparam logic [1:0] PIXEL = 2'd2;
  localparam logic [1:0] STA   = 2'd3;
  logic [1:0]    state;
  logic [PW-1:0] pix_cnt;
  logic [5:0]    bias_cnt;
  logic [23:0]   part;
  logic [31:0]   scan_data;
  logic [6:0]    scan_ptr;
  logic [15:0]   bias_q;
  logic [5:0]    bias_ptr;
  logic          sta_q;
  logic          busy_q;
  logic          bias_fire;
  logic          pix_fire;
  logic [1:0]    lane;
  logic          word_done;
  assign bias_ready = state == BIAS;
  assign pix_ready  = state == PIXEL;
  assign bias_fire  = bias_valid & bias_ready;
  assign pix_fire   = pix_valid & pix_ready;
  assign lane       = pix_cnt[1:0];
  assign word_done  = pix_fire & (lane == 2'd3);
  assign scan_o     = {scan_data, 1'b0, scan_ptr};
  assign bias_o     = {bias_q, 2'b00, bias_ptr};
  assign sta        = sta_q;
  assign done       = sta_q;
  assign busy       = busy_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pix_cnt   <= '0;
      bias_cnt  <= '0;
      part      <= '0;
      scan_data <= '0;
      scan_ptr  <= 7'(SCAN_IDLE);
      bias_q    <= '0;
      bias_ptr  <= 6'(BIAS_IDLE);
      sta_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      // sta lands one cycle after the last scan word so the buffer already holds it
      sta_q    <= state == STA;
      busy_q   <= state == IDLE ? start : 1'b1;
      bias_ptr <= bias_fire ? bias_cnt : 6'(BIAS_IDLE);
      scan_ptr <= word_done ? 7'(pix_cnt >> 2) : 7'(SCAN_IDLE);
      if (bias_fire) bias_q <= bias_data;
      if (bias_fire) bias_cnt <= bias_cnt + 6'd1;
      if (word_done) scan_data <= {pix_data, part};
      if (pix_fire && !word_done) part[{lane, 3'b000} +: 8] <= pix_data;
      if (pix_fire) pix_cnt <= pix_cnt + PW'(1);
      case (state)
        IDLE:    if (start) state <= skip_bias ? PIXEL : BIAS;
        BIAS:    if (bias_fire && bias_cnt == 6'(NUM_BIAS - 1)) state <= PIXEL;
        PIXEL:   if (pix_fire && pix_cnt == PW'(NUM_PIX - 1)) state <= STA;
        default: begin
          state    <= IDLE;
          pix_cnt  <= '0;
          bias_cnt <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_conv_1st_loader.sv
// tb_conv_1st_loader: directed checks of bias load, pixel packing, sta timing, skip_bias and mid-frame reset
module tb_conv_1st_loader;
  localparam int NUM_PIX  = 300;
  localparam int NUM_BIAS = 34;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        skip_bias = 1'b0;
  logic        bias_valid = 1'b0;
  logic [15:0] bias_data = '0;
  logic        bias_ready;
  logic        pix_valid = 1'b0;
  logic [7:0]  pix_data = '0;
  logic        pix_ready;
  logic [39:0] scan_o;
  logic [23:0] bias_o;
  logic        sta;
  logic        busy;
  logic        done;
  int tests = 0;
  int errs = 0;
  conv_1st_loader dut (
    .clk(clk), .rst(rst), .start(start), .skip_bias(skip_bias),
    .bias_valid(bias_valid), .bias_data(bias_data), .bias_ready(bias_ready),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .scan_o(scan_o), .bias_o(bias_o), .sta(sta), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic do_start(input bit skip);
    start = 1'b1;
    skip_bias = skip;
    tick();
    start = 1'b0;
    skip_bias = 1'b0;
    chk("busy_rise", busy, 1);
    chk("bias_ready_start", bias_ready, !skip);
    chk("pix_ready_start", pix_ready, skip);
  endtask
  task automatic load_biases();
    for (int k = 0; k < NUM_BIAS; k++) begin
      bias_valid = 1'b1;
      bias_data = 16'(k + 1);
      tick();
      chk("bias_word", bias_o, {16'(k + 1), 2'b00, 6'(k)});
      chk("bias_pix_ready", pix_ready, k == NUM_BIAS - 1);
    end
    bias_valid = 1'b0;
    tick();
    chk("bias_ptr_back_idle", bias_o, {16'h0022, 2'b00, 6'd63});
    chk("bias_ready_low", bias_ready, 0);
  endtask
  task automatic load_pixels(input int count, input bit gap);
    logic [31:0] w;
    for (int n = 0; n < count; n++) begin
      pix_valid = 1'b1;
      pix_data = 8'(n);
      tick();
      pix_valid = 1'b0;
      if (n % 4 == 3) begin
        w = {8'(n), 8'(n - 1), 8'(n - 2), 8'(n - 3)};
        chk("scan_word", scan_o, {w, 1'b0, 7'(n / 4)});
      end else chk("scan_idle", scan_o[6:0], 7'd127);
      if (n == 3) chk("scan_first", scan_o, {32'h03020100, 8'd0});
      if (n == NUM_PIX - 1) chk("scan_last", scan_o, {32'h2B2A2928, 8'd74});
      chk("pix_bias_ptr", bias_o[5:0], 6'd63);
      chk("pix_bias_ready", bias_ready, 0);
      chk("pix_ready", pix_ready, n < NUM_PIX - 1);
      chk("pix_sta", sta, 0);
      if (gap && n < count - 1) begin
        tick();
        chk("gap_idle", scan_o[6:0], 7'd127);
        chk("gap_ready", pix_ready, 1);
      end
    end
    if (count == NUM_PIX) begin
      chk("pre_sta_busy", busy, 1);
      tick();
      chk("sta_pulse", {sta, done, busy}, 3'b111);
      chk("sta_scan_idle", scan_o[6:0], 7'd127);
      tick();
      chk("sta_end", {sta, done, busy}, 3'b000);
      chk("ready_end", {bias_ready, pix_ready}, 2'b00);
    end
  endtask
  initial begin
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_scan", scan_o, 40'h7F);
      chk("idle_bias", bias_o, 24'h3F);
      chk("idle_ctl", {sta, done, busy, bias_ready, pix_ready}, 5'b0);
    end
    do_start(1'b0);
    load_biases();
    load_pixels(NUM_PIX, 1'b0);
    do_start(1'b1);
    chk("skip_bias_held", bias_o, {16'h0022, 2'b00, 6'd63});
    load_pixels(NUM_PIX, 1'b1);
    do_start(1'b1);
    load_pixels(150, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst_scan", scan_o, 40'h7F);
    chk("rst_bias", bias_o, 24'h3F);
    chk("rst_ctl", {sta, done, busy, bias_ready, pix_ready}, 5'b0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_ctl", {sta, done, busy, bias_ready, pix_ready}, 5'b0);
    end
    do_start(1'b1);
    load_pixels(NUM_PIX, 1'b0);
    chk("final_bias", bias_o, 24'h3F);
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
